// File: rtl/fetch_unit_if.sv
// Fetch unit bus: control inputs, jump-table write port, instruction memory port and decoder outputs.
// CycleCnt exists only when FETCH_CYCLE_COUNT_EN is defined.
interface fetch_unit_if #(
  parameter int PC_W = 10
);
  logic            Start;
  logic            BranchTaken;
  logic [1:0]      Jptr;
  logic            Stall;
  logic            LutWe;
  logic [1:0]      LutAddr;
  logic [PC_W-1:0] LutData;
  logic [PC_W-1:0] ImemAddr;
  logic            ImemRe;
  logic [8:0]      ImemData;
  logic [8:0]      mach_code;
  logic            InstValid;
  logic            Done;
`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0]     CycleCnt;
`endif

  modport master (
    output Start, BranchTaken, Jptr, Stall, LutWe, LutAddr, LutData, ImemData,
    input  ImemAddr, ImemRe, mach_code, InstValid, Done
`ifdef FETCH_CYCLE_COUNT_EN
    , input CycleCnt
`endif
  );

  modport slave (
    input  Start, BranchTaken, Jptr, Stall, LutWe, LutAddr, LutData, ImemData,
    output ImemAddr, ImemRe, mach_code, InstValid, Done
`ifdef FETCH_CYCLE_COUNT_EN
    , output CycleCnt
`endif
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, 4-entry jump table, IR register and IDLE/FILL/RUN/HALT sequencer.
// Optional active-cycle counter on CycleCnt when FETCH_CYCLE_COUNT_EN is defined.
module fetch_unit #(
  parameter int         PC_W      = 10,
  parameter logic [8:0] HALT_CODE = 9'h1FF
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  fetch_unit_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_HALT} state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [8:0]      r_ir;
  logic            r_valid;
  logic            r_done;
  logic [PC_W-1:0] r_lut [4];

  logic [PC_W-1:0] w_pc_inc;
  logic            w_run_go;
  logic            w_branch;

  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_run_go = (r_state == S_RUN) && !bus.Stall;
  // A branch only counts when the instruction it belongs to is live
  assign w_branch = w_run_go && r_valid && bus.BranchTaken;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.Start) begin
            r_pc    <= '0;
            r_state <= S_FILL;
          end
        end
        S_FILL: begin
          r_pc    <= w_pc_inc;
          r_valid <= 1'b0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_branch) begin
            r_pc    <= r_lut[bus.Jptr];
            r_valid <= 1'b0;
            r_state <= S_FILL;
          end else if (w_run_go && bus.ImemData == HALT_CODE) begin
            r_valid <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_HALT;
          end else if (w_run_go) begin
            r_ir    <= bus.ImemData;
            r_valid <= 1'b1;
            r_pc    <= w_pc_inc;
          end
        end
        S_HALT: begin
          if (bus.Start) begin
            r_done  <= 1'b0;
            r_pc    <= '0;
            r_state <= S_FILL;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Nonblocking write means a same-cycle branch still reads the old entry
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 4; i++) r_lut[i] <= '0;
    end else if (bus.LutWe) begin
      r_lut[bus.LutAddr] <= bus.LutData;
    end
  end

`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if ((r_state == S_IDLE || r_state == S_HALT) && bus.Start) begin
      r_cnt <= '0;
    end else if ((r_state == S_FILL || r_state == S_RUN) && r_cnt != 16'hFFFF) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign bus.CycleCnt = r_cnt;
`endif

  // Memory output freezes while stalled so the pending word is not lost
  assign bus.ImemRe    = !((r_state == S_RUN) && bus.Stall);
  assign bus.ImemAddr  = r_pc;
  assign bus.mach_code = r_ir;
  assign bus.InstValid = r_valid;
  assign bus.Done      = r_done;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected instruction words, monitors pop them.
// Covers start latency, halt, branch bubbles, stall, reset, PC wrap and optional cycle counter.
module tb_fetch_unit;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fetch_unit_if #(.PC_W(10)) bus_a ();
  fetch_unit_if #(.PC_W(4))  bus_b ();

  fetch_unit #(.PC_W(10), .HALT_CODE(9'h1FF)) dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_a));
  fetch_unit #(.PC_W(4),  .HALT_CODE(9'h1FF)) dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_b));

  logic [8:0] mem_a [0:1023];
  logic [8:0] mem_b [0:15];
  logic [8:0] rd_a;
  logic [8:0] rd_b;
  logic [8:0] exp_a [$];
  logic [8:0] exp_b [$];
  bit         last_stall_a;
  bit         last_stall_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus_a.ImemRe) rd_a <= mem_a[bus_a.ImemAddr];
  always @(posedge clk) if (bus_b.ImemRe) rd_b <= mem_b[bus_b.ImemAddr];
  assign bus_a.ImemData = rd_a;
  assign bus_b.ImemData = rd_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus_a.Done) break;
    end
    check(name, {31'd0, bus_a.Done}, 32'd1);
    check({name, "_valid"}, {31'd0, bus_a.InstValid}, 32'd0);
  endtask

  task automatic start_a();
    bus_a.Start = 1'b1;
    step();
    bus_a.Start = 1'b0;
  endtask

  // A word is newly presented when valid and the previous edge was not stalled
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_a.delete();
      last_stall_a = 1'b0;
    end else begin
      if (bus_a.InstValid && !last_stall_a) begin
        if (exp_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_a_unexpected: got %0h expected none", bus_a.mach_code);
        end else begin
          check("sb_a_word", {23'd0, bus_a.mach_code}, {23'd0, exp_a.pop_front()});
        end
      end
      last_stall_a = bus_a.Stall;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_b.delete();
      last_stall_b = 1'b0;
    end else begin
      if (bus_b.InstValid && !last_stall_b) begin
        if (exp_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_b_unexpected: got %0h expected none", bus_b.mach_code);
        end else begin
          check("sb_b_word", {23'd0, bus_b.mach_code}, {23'd0, exp_b.pop_front()});
        end
      end
      last_stall_b = bus_b.Stall;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 1024; i++) mem_a[i] = 9'h000;
    for (int i = 0; i < 16; i++) mem_b[i] = 9'h100 + 9'(i);
    mem_a[0] = 9'h041; mem_a[1] = 9'h052; mem_a[2] = 9'h063; mem_a[3] = 9'h1FF;
    mem_a[10'h020] = 9'h0AA; mem_a[10'h021] = 9'h0BB; mem_a[10'h022] = 9'h1FF;
    bus_a.Start = 0; bus_a.BranchTaken = 0; bus_a.Jptr = 0; bus_a.Stall = 0;
    bus_a.LutWe = 0; bus_a.LutAddr = 0; bus_a.LutData = 0;
    bus_b.Start = 0; bus_b.BranchTaken = 0; bus_b.Jptr = 0; bus_b.Stall = 0;
    bus_b.LutWe = 0; bus_b.LutAddr = 0; bus_b.LutData = 0;

    // Reset state
    rst_n = 1'b0;
    #3;
    check("rst_valid", {31'd0, bus_a.InstValid}, 32'd0);
    check("rst_done", {31'd0, bus_a.Done}, 32'd0);
    check("rst_code", {23'd0, bus_a.mach_code}, 32'd0);
    check("rst_addr", {22'd0, bus_a.ImemAddr}, 32'd0);
    check("rst_re", {31'd0, bus_a.ImemRe}, 32'd1);
    check("rst_addr_b", {28'd0, bus_b.ImemAddr}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Straight-line program: latency 3, three words, then halt
    exp_a.push_back(9'h041); exp_a.push_back(9'h052); exp_a.push_back(9'h063);
    start_a();
    cnt = 1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus_a.InstValid) break;
      cnt++;
    end
    check("start_latency", cnt, 32'd3);
    wait_done("halt1");
    check("halt1_code", {23'd0, bus_a.mach_code}, 32'h063);
`ifdef FETCH_CYCLE_COUNT_EN
    check("cnt_at_halt", {16'd0, bus_a.CycleCnt}, 32'd5);
    repeat (3) @(negedge clk);
    check("cnt_held", {16'd0, bus_a.CycleCnt}, 32'd5);
`endif
    step();

    // Branch via Lut[2]; same-cycle rewrite of Lut[2] must not affect it
    bus_a.LutWe = 1; bus_a.LutAddr = 2; bus_a.LutData = 10'h020;
    step();
    bus_a.LutWe = 0;
    exp_a.push_back(9'h041); exp_a.push_back(9'h052);
    exp_a.push_back(9'h0AA); exp_a.push_back(9'h0BB);
    start_a();
`ifdef FETCH_CYCLE_COUNT_EN
    @(negedge clk);
    check("cnt_restart", {16'd0, bus_a.CycleCnt}, 32'd0);
`endif
    step(); step(); step();
    bus_a.BranchTaken = 1; bus_a.Jptr = 2;
    bus_a.LutWe = 1; bus_a.LutAddr = 2; bus_a.LutData = 10'h030;
    step();
    bus_a.BranchTaken = 0; bus_a.LutWe = 0;
    @(negedge clk);
    check("bubble1", {31'd0, bus_a.InstValid}, 32'd0);
    check("branch_target", {22'd0, bus_a.ImemAddr}, 32'h020);
    @(negedge clk);
    check("bubble2", {31'd0, bus_a.InstValid}, 32'd0);
    wait_done("halt2");
    step();

    // Stall for three cycles on 052; branch with no live instruction and branch under stall both ignored
    exp_a.push_back(9'h041); exp_a.push_back(9'h052); exp_a.push_back(9'h063);
    start_a();
    step();
    bus_a.BranchTaken = 1; bus_a.Jptr = 2;
    step();
    bus_a.BranchTaken = 0;
    @(negedge clk);
    check("no_branch_addr", {22'd0, bus_a.ImemAddr}, 32'd2);
    step();
    bus_a.Stall = 1;
    for (int s = 0; s < 3; s++) begin
      bus_a.BranchTaken = (s == 1);
      @(negedge clk);
      check("stall_re", {31'd0, bus_a.ImemRe}, 32'd0);
      check("stall_code", {23'd0, bus_a.mach_code}, 32'h052);
      check("stall_addr", {22'd0, bus_a.ImemAddr}, 32'd3);
      step();
    end
    bus_a.Stall = 0; bus_a.BranchTaken = 0;
    wait_done("halt3");
    step();

    // Asynchronous reset in the middle of a run
    exp_a.push_back(9'h041);
    start_a();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus_a.InstValid) break;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, bus_a.InstValid}, 32'd0);
    check("arst_code", {23'd0, bus_a.mach_code}, 32'd0);
    check("arst_addr", {22'd0, bus_a.ImemAddr}, 32'd0);
    check("arst_re", {31'd0, bus_a.ImemRe}, 32'd1);
`ifdef FETCH_CYCLE_COUNT_EN
    check("arst_cnt", {16'd0, bus_a.CycleCnt}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check("post_rst_idle_valid", {31'd0, bus_a.InstValid}, 32'd0);
      check("post_rst_idle_addr", {22'd0, bus_a.ImemAddr}, 32'd0);
    end
    check("sb_a_drained", exp_a.size(), 32'd0);

    // PC wrap with a 4-bit PC: 16 non-halt words keep fetching past F
    for (int k = 3; k <= 21; k++) exp_b.push_back(mem_b[(k - 3) % 16]);
    step();
    bus_b.Start = 1'b1;
    step();
    bus_b.Start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check("wrap_addr", {28'd0, bus_b.ImemAddr}, 32'((k - 1) % 16));
    end
    @(posedge clk);
    #1;
    bus_b.Stall = 1'b1;
    repeat (3) @(negedge clk);
    check("sb_b_drained", exp_b.size(), 32'd0);
    check("wrap_done", {31'd0, bus_b.Done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
